// File: rtl/cmd_stream_parser_if.sv
// Upstream word stream and downstream target bus of the command stream parser.
// The bench or command FIFO side uses master; the parser uses slave.
interface cmd_stream_parser_if #(
    parameter int DATA_W = 8,
    parameter int N_TGT  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [N_TGT-1:0]  cmd_mask;
    logic [N_TGT-1:0]  tgt_ack;
    logic              cmd_done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output in_data, in_valid, tgt_ack,
        input  in_ready, out_data, out_valid, cmd_mask, cmd_done, err, err_code
    );

    modport slave (
        input  in_data, in_valid, tgt_ack,
        output in_ready, out_data, out_valid, cmd_mask, cmd_done, err, err_code
    );
endinterface

// File: rtl/cmd_stream_parser.sv
// Length-prefixed command frame parser: buffers a whole payload, then hands each word to a target mask.
// Optional load-phase idle timeout is enabled with the CMD_TIMEOUT_EN macro.
module cmd_stream_parser #(
    parameter int DATA_W  = 8,
    parameter int N_TGT   = 8,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 65535
) (
    input logic                clk,
    input logic                rst_n,
    cmd_stream_parser_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, MASK, LOAD, DROP, SEND} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] len, count, rd, out_data_q;
    logic [N_TGT-1:0]  mask, acked, ack_sel;
    logic [DATA_W-1:0] buffer [DEPTH];
    logic [AW-1:0]     rd_nxt;
    logic              xfer, retire, last_rd, last_in, reject, err_q, tmo_hit, loading;
    logic [1:0]        reject_code, err_code_q;

    assign bus.in_ready  = rst_n && (state != SEND);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign loading       = (state == MASK) || (state == LOAD) || (state == DROP);
    assign ack_sel       = acked | (bus.tgt_ack & mask);
    assign retire        = (state == SEND) && (ack_sel == mask);
    assign last_rd       = (rd == len - DATA_W'(1));
    assign last_in       = (count == len - DATA_W'(1));
    assign rd_nxt        = rd[AW-1:0] + AW'(1);

    assign bus.out_valid = (state == SEND);
    assign bus.cmd_mask  = (state == SEND) ? mask : '0;
    assign bus.out_data  = out_data_q;
    assign bus.cmd_done  = retire && last_rd;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Counts consecutive cycles without a transfer while a frame is being taken in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (loading && !xfer) begin
            idle_cnt <= idle_cnt + TW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    assign tmo_hit = loading && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Frame validation happens on the mask word; an oversize length wins over an empty mask.
    always_comb begin
        state_n     = state;
        reject      = 1'b0;
        reject_code = 2'd0;
        case (state)
            IDLE: if (xfer) state_n = MASK;
            MASK: begin
                if (xfer) begin
                    if (len == '0) begin
                        reject      = 1'b1;
                        reject_code = 2'd1;
                        state_n     = IDLE;
                    end else if (len > DEPTH_W) begin
                        reject      = 1'b1;
                        reject_code = 2'd2;
                        state_n     = DROP;
                    end else if (bus.in_data[N_TGT-1:0] == '0) begin
                        reject      = 1'b1;
                        reject_code = 2'd3;
                        state_n     = DROP;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD: if (xfer && last_in) state_n = SEND;
            DROP: if (xfer && last_in) state_n = IDLE;
            SEND: if (retire && last_rd) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo_hit) begin
            state_n     = IDLE;
            reject      = 1'b1;
            reject_code = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len        <= '0;
            mask       <= '0;
            count      <= '0;
            rd         <= '0;
            acked      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            err_q <= reject;
            if (reject) err_code_q <= reject_code;
            case (state)
                IDLE: if (xfer) len <= bus.in_data;
                MASK: begin
                    if (xfer) begin
                        mask  <= bus.in_data[N_TGT-1:0];
                        count <= '0;
                    end
                end
                LOAD, DROP: begin
                    if (xfer) begin
                        count <= count + DATA_W'(1);
                        // Word 0 is staged on the last load so it is valid as soon as SEND starts.
                        if (state == LOAD && last_in) begin
                            rd         <= '0;
                            acked      <= '0;
                            out_data_q <= (count == '0) ? bus.in_data : buffer[0];
                        end
                    end
                end
                SEND: begin
                    if (retire) begin
                        acked <= '0;
                        rd    <= rd + DATA_W'(1);
                        if (!last_rd) out_data_q <= buffer[rd_nxt];
                    end else begin
                        acked <= ack_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && xfer) buffer[count[AW-1:0]] <= bus.in_data;
    end
endmodule
